// File: rtl/cu_mul_unit_if.sv
// Sequencer/crossbar-facing bus of the multiply/MAC unit.
// The master modport is the sequencer + crossbar side; the slave modport is the unit.
interface cu_mul_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  ps_mul_en;
  logic [1:0]            ps_mul_op;
  logic                  ps_mul_sgn;
  logic                  ps_mul_frac;
  logic                  ps_mul_sat;
  logic [DATA_WIDTH-1:0] xb_mul_rx;
  logic [DATA_WIDTH-1:0] xb_mul_ry;
  logic [DATA_WIDTH-1:0] mul_xb_rn;
  logic                  mul_ps_busy;
  logic                  mul_ps_done;
  logic                  mul_ps_mv;
  logic                  mul_ps_mn;

  modport master (
    output ps_mul_en, ps_mul_op, ps_mul_sgn, ps_mul_frac, ps_mul_sat,
    output xb_mul_rx, xb_mul_ry,
    input  mul_xb_rn, mul_ps_busy, mul_ps_done, mul_ps_mv, mul_ps_mn
  );

  modport slave (
    input  ps_mul_en, ps_mul_op, ps_mul_sgn, ps_mul_frac, ps_mul_sat,
    input  xb_mul_rx, xb_mul_ry,
    output mul_xb_rn, mul_ps_busy, mul_ps_done, mul_ps_mv, mul_ps_mn
  );
endinterface

// File: rtl/cu_mul_unit.sv
// Multi-cycle radix-2 multiply / multiply-accumulate unit with a wide MR accumulator,
// result-field extraction, overflow detection and optional saturation.
module cu_mul_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic          clk,
  input  logic          reset_n,
  cu_mul_unit_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_MAC, OP_MSUB, OP_CLRMR} op_e;

  state_e                state, state_next;
  op_e                   op_q;
  logic                  sgn_q, frac_q, sat_q;
  logic [PW-1:0]         mcand;
  logic [DW-1:0]         mplier;
  logic [PW-1:0]         prod;
  logic [CW-1:0]         cnt;
  logic [ACC_WIDTH-1:0]  mr;
  logic [DW-1:0]         rn_q;
  logic                  mv_q, mn_q;

  logic                  accept;
  logic [ACC_WIDTH-1:0]  p_ext, mr_next;
  logic [DW-1:0]         field, rn_next;
  logic                  fits;

  assign accept = ((state == IDLE) || (state == DONE)) && bus.ps_mul_en;

  // NOTE: all state, datapath included, is reset so an abort mid-operation leaves nothing stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (state == DONE) state_next = IDLE;
        if (bus.ps_mul_en)
          state_next = (op_e'(bus.ps_mul_op) == OP_CLRMR) ? ACC : CALC;
      end
      CALC:    if (cnt == LAST_BIT) state_next = ACC;
      ACC:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mul_ps_busy = 1'b0;
    bus.mul_ps_done = 1'b0;
    unique case (state)
      CALC, ACC: bus.mul_ps_busy = 1'b1;
      DONE:      bus.mul_ps_done = 1'b1;
      default:   ;
    endcase
  end

  // Product extension, MR update and result-field selection for the ACC edge.
  always_comb begin
    p_ext = sgn_q ? {{(ACC_WIDTH-PW){prod[PW-1]}}, prod}
                  : {{(ACC_WIDTH-PW){1'b0}}, prod};
    // Shift after widening: the guard bit keeps -1 * -1 positive in fractional mode.
    if (frac_q) p_ext = p_ext << 1;

    mr_next = mr;
    unique case (op_q)
      OP_MUL:   mr_next = p_ext;
      OP_MAC:   mr_next = mr + p_ext;
      OP_MSUB:  mr_next = mr - p_ext;
      OP_CLRMR: mr_next = '0;
      default:  mr_next = mr;
    endcase

    if (frac_q) begin
      field = mr_next[PW-1:DW];
      fits  = sgn_q ? ((&mr_next[ACC_WIDTH-1:PW-1]) || ~(|mr_next[ACC_WIDTH-1:PW-1]))
                    : ~(|mr_next[ACC_WIDTH-1:PW]);
    end else begin
      field = mr_next[DW-1:0];
      fits  = sgn_q ? ((&mr_next[ACC_WIDTH-1:DW-1]) || ~(|mr_next[ACC_WIDTH-1:DW-1]))
                    : ~(|mr_next[ACC_WIDTH-1:DW]);
    end

    rn_next = field;
    if (!fits && sat_q) begin
      if (sgn_q) rn_next = mr_next[ACC_WIDTH-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else       rn_next = mr_next[ACC_WIDTH-1] ? '0 : '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OP_MUL;
      sgn_q  <= 1'b0;
      frac_q <= 1'b0;
      sat_q  <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      mr     <= '0;
      rn_q   <= '0;
      mv_q   <= 1'b0;
      mn_q   <= 1'b0;
    end else if (accept) begin
      op_q   <= op_e'(bus.ps_mul_op);
      sgn_q  <= bus.ps_mul_sgn;
      frac_q <= bus.ps_mul_frac;
      sat_q  <= bus.ps_mul_sat;
      if (op_e'(bus.ps_mul_op) != OP_CLRMR) begin
        mcand  <= bus.ps_mul_sgn ? {{DW{bus.xb_mul_rx[DW-1]}}, bus.xb_mul_rx}
                                 : {{DW{1'b0}}, bus.xb_mul_rx};
        mplier <= bus.xb_mul_ry;
        prod   <= '0;
        cnt    <= '0;
      end
    end else if (state == CALC) begin
      // The multiplier MSB carries negative weight in signed mode.
      if (mplier[0])
        prod <= (sgn_q && (cnt == LAST_BIT)) ? prod - mcand : prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end else if (state == ACC) begin
      mr   <= mr_next;
      rn_q <= rn_next;
      mv_q <= ~fits;
      mn_q <= sgn_q & rn_next[DW-1];
    end
  end

  assign bus.mul_xb_rn = rn_q;
  assign bus.mul_ps_mv = mv_q;
  assign bus.mul_ps_mn = mn_q;
endmodule

// File: doc/cu_mul_unit.md
Name: cu_mul_unit

Overview:
Multi-cycle multiply/multiply-accumulate compute unit, directly upstream of the crossbar.
- Takes operands from the crossbar bypass outputs (xb_cu_rx/xb_cu_ry) and drives the crossbar's mul_xb_rn input.
- Keeps a wide accumulator register MR.
- Uses a start/busy/done handshake with the program sequencer (ps). The sequencer raises the crossbar enable ps_xb_cuEn[1] when mul_ps_done is seen.

Parameters:
DATA_WIDTH, 16, operand/result word width (DW)
ACC_WIDTH, 40, MR width; must be at least 2*DW+1 (guard bits)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
ps_mul_en  input  1  start strobe; sampled only in IDLE or DONE
ps_mul_op  input  2  00 MUL (MR=P), 01 MAC (MR=MR+P), 10 MSUB (MR=MR-P), 11 CLRMR (MR=0)
ps_mul_sgn  input  1  1 = signed two's-complement operands, 0 = unsigned
ps_mul_frac  input  1  1 = fractional 1.(DW-1) mode, 0 = integer
ps_mul_sat  input  1  1 = saturate delivered result
xb_mul_rx, xb_mul_ry  input  DW  operands from the crossbar
mul_xb_rn  output  DW  result word to the crossbar
mul_ps_busy  output  1  high in CALC and ACC
mul_ps_done  output  1  high for exactly one cycle (DONE state)
mul_ps_mv  output  1  overflow: MR did not fit the result field
mul_ps_mn  output  1  negative: MSB of mul_xb_rn when sgn=1, else 0

Behaviour:
- Reset (any time, including mid-operation): abort the operation; state=IDLE; MR=0; mul_xb_rn=0; busy, done, mv, mn all 0.
- FSM states: IDLE, CALC, ACC, DONE.
  - IDLE/DONE with en=1, op!=11: latch rx, ry, op, sgn, frac, sat; clear the partial product; counter=0; go to CALC.
  - IDLE/DONE with en=1, op=11: latch the mode bits; go to ACC.
  - DONE with en=0: go to IDLE.
  - IDLE with en=0: stay in IDLE.
- Operands are captured at the sampling edge. Later input changes have no effect.
- ps_mul_en in CALC or ACC is ignored; no queuing.
- CALC: radix-2 shift-add, one multiplier bit per cycle, exactly DW cycles.
  - Signed mode: sign-extend both operands to 2*DW bits and use the MSB weight as negative (Baugh-Wooley or equivalent). The product P is an exact 2*DW-bit signed product.
  - Unsigned mode: P is the exact unsigned product.
  - After DW cycles, go to ACC.
- ACC (1 cycle):
  - frac=1: P is shifted left by 1.
  - P is sign-extended (sgn=1) or zero-extended (sgn=0) to ACC_WIDTH.
  - MR is updated per op. Arithmetic is modulo 2^ACC_WIDTH.
  - At the same edge, mul_xb_rn, mv and mn are registered; go to DONE.
- Result field:
  - frac=0: field = MR[DW-1:0]. It fits if MR[ACC-1:DW-1] are all equal (sgn=1), or MR[ACC-1:DW]==0 (sgn=0).
  - frac=1: field = MR[2DW-1:DW]. It fits if MR[ACC-1:2DW-1] are all equal (sgn=1), or MR[ACC-1:2DW]==0 (sgn=0).
- mv=1 if and only if the value does not fit, independent of sat.
- If it does not fit and sat=1:
  - sgn=1: output is max-positive (0x7FFF) if MR[ACC-1]=0, else min-negative (0x8000).
  - sgn=0: output is 0xFFFF if MR[ACC-1]=0, else 0x0000 (underflow).
- If it does not fit and sat=0: output the raw field (wraps). MR itself is never saturated.
- Latency, counted from the sampling edge E0:
  - MUL/MAC/MSUB: done is high during the cycle after edge E(DW+1) (E17 for DW=16).
  - CLRMR: done is high after edge E1.
- mul_xb_rn, mv and mn hold until the next ACC update or reset.
- Throughput: a new en in the DONE cycle is accepted. Back-to-back initiation interval is DW+2 cycles.

Test Plan:
- Reset: set reset_n low for 1 cycle, 5 cycles into a MUL. Required: busy=done=mv=0 and rn=0 immediately. A following CLRMR gives rn=0, and a MAC of 2*3 gives rn=0x0006 (MR was cleared).
- Signed integer MUL: rx=0x0003, ry=0xFFFB, sgn=1, frac=0. Required: busy high E0..E17, done high exactly one cycle after E17, rn=0xFFF1, mn=1, mv=0.
- Accumulate/saturate:
  - MUL 100*200 gives rn=0x4E20.
  - A following MAC 100*200 with sat=0 gives rn=0x9C40, mv=1, mn=1.
  - The same sequence with sat=1 gives rn=0x7FFF, mv=1, mn=0.
  - MSUB 100*200 (sat=0) after the sat=0 MAC returns rn=0x4E20, mv=0.
- Fractional, sgn=1, frac=1:
  - 0x4000*0x4000 gives rn=0x2000, mv=0.
  - 0x8000*0x8000 with sat=1 gives rn=0x7FFF, mv=1.
  - 0x8000*0x8000 with sat=0 gives rn=0x8000, mv=1.
- Unsigned: 0xFFFF*0x0002, sgn=0, sat=0 gives rn=0xFFFE, mv=1, mn=0. Then CLRMR gives rn=0x0000 with done after E1. MSUB 1*1 with sat=1 gives rn=0x0000, mv=1.
- Handshake:
  - Hold en=1 continuously with op=MUL. Required: ops start only at E0 and in each DONE cycle, and done pulses every 18 cycles.
  - Changing rx mid-CALC does not change the result.
